fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of FIFO read data and output data.
REQ-002 Parameter FRAMELEN, default 16, number of output transfers per frame; legal range 1..256.
REQ-003 iRCLK  input  1  read-side clock; all state changes on rising edge.
REQ-004 iRRST  input  1  reset, asynchronous, active-high.
REQ-005 iEN  input  1  fetch enable; low stops new FIFO pops, buffered data still drains.
REQ-006 iEMPT  input  1  FIFO empty flag, registered in the iRCLK domain.
REQ-007 iRDAT  input  DATAWIDTH  FIFO head word, valid in any cycle with iEMPT=0.
REQ-008 oRINC  output  1  FIFO pop strobe; one word consumed per cycle high.
REQ-009 oVALID  output  1  oDATA holds a valid word.
REQ-010 oDATA  output  DATAWIDTH  output word, head of internal buffer.
REQ-011 iREADY  input  1  downstream accepts oDATA when oVALID and iREADY are both high.
REQ-012 oLAST  output  1  current oDATA is the final word of a frame.
REQ-013 oCNT  output  8  index of current word within frame, 0..FRAMELEN-1.

Function
REQ-014 Internal buffer SHALL be 2 entries (slot0 = head, slot1), with occupancy count occ in 0..2.
REQ-015 oRINC SHALL be combinational: iEN & ~iEMPT & ~startup & (occ < 2).
REQ-016 oRINC SHALL never be high while iEMPT=1.
REQ-017 On a rising edge with oRINC=1, iRDAT SHALL be written into the lowest free slot, taking any same-edge pop into account.
REQ-018 oVALID SHALL equal (occ != 0); oDATA SHALL equal slot0.
REQ-019 Transfer = oVALID & iREADY; on a transfer, slot1 SHALL shift into slot0 and occ SHALL decrement, unless a push occurs on the same edge.
REQ-020 Push and transfer on the same edge: occ unchanged; the new word enters the slot vacated by the shift.
REQ-021 Steady state with iEMPT=0, iEN=1 and iREADY=1 SHALL sustain one word per cycle.
REQ-022 Latency SHALL be one cycle: a word popped at edge N appears on oDATA after edge N when the buffer was empty.
REQ-023 oDATA and oVALID SHALL hold stable while oVALID=1 and iREADY=0.
REQ-024 oCNT SHALL increment on each transfer and wrap from FRAMELEN-1 to 0; it is unchanged otherwise.
REQ-025 oLAST SHALL be oVALID & (oCNT == FRAMELEN-1); with FRAMELEN=1, oLAST = oVALID.
REQ-026 Deassertion of iEN SHALL take effect in the same cycle (oRINC low); buffered words SHALL still be output.
REQ-027 Word order at oDATA SHALL be identical to FIFO pop order; there SHALL be no loss or duplication.

Reset
REQ-028 While iRRST=1: occ=0, oVALID=0, oRINC=0, oCNT=0, oLAST=0, slot contents=0.
REQ-029 A startup register SHALL be set by reset and cleared on the first iRCLK edge after release, so oRINC stays 0 for that first cycle. This masks the FIFO empty flag, which is not valid out of reset.
REQ-030 Reset asserted mid-operation SHALL discard buffered words and restart frame counting at 0.

Verification
REQ-031 Reset, then iEMPT=1 for 10 cycles -> oRINC=0, oVALID=0, oCNT=0 throughout.
REQ-032 FIFO preloaded with 0x01..0x05, iEN=1, iREADY=1 -> oRINC high for 5 consecutive cycles; oDATA = 0x01..0x05 on consecutive cycles starting one cycle after the first pop.
REQ-033 iREADY=0 with 3 words available -> exactly 2 pops, then oRINC=0, oDATA holds 0x01. Raise iREADY -> outputs 0x01, 0x02, 0x03 in order.
REQ-034 FRAMELEN=4, 9 words streamed -> oCNT sequence 0,1,2,3,0,1,2,3,0; oLAST high on the 4th and 8th words only.
REQ-035 iEN dropped with occ=2 and FIFO non-empty -> oRINC=0 the same cycle; both buffered words still output; no further pops until iEN=1.
REQ-036 iRRST pulsed while occ=2 and oCNT=2 -> oVALID=0 and oCNT=0 immediately. First pop occurs no earlier than the second edge after release.

Source files
------------

// File: rtl/fifo_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : fifo_reader_if                                     |
// | Description : FIFO read port plus downstream valid/ready stream  |
// |               with frame position, bundled for fifo_reader.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface fifo_reader_if #(
  parameter int DATAWIDTH = 8
);
  logic                 iEN;
  logic                 iEMPT;
  logic [DATAWIDTH-1:0] iRDAT;
  logic                 oRINC;
  logic                 oVALID;
  logic [DATAWIDTH-1:0] oDATA;
  logic                 iREADY;
  logic                 oLAST;
  logic [7:0]           oCNT;

  // Reader side (the design)
  modport slave (
    input  iEN, iEMPT, iRDAT, iREADY,
    output oRINC, oVALID, oDATA, oLAST, oCNT
  );

  // Environment side (FIFO plus downstream consumer)
  modport master (
    output iEN, iEMPT, iRDAT, iREADY,
    input  oRINC, oVALID, oDATA, oLAST, oCNT
  );
endinterface
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_reader                                        |
// | Description : Pops words from a FIFO into a 2-entry skid buffer  |
// |               and streams them out with valid/ready, tracking    |
// |               the word position inside fixed-length frames.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module fifo_reader #(
  parameter int DATAWIDTH = 8,
  parameter int FRAMELEN  = 16
) (
  input  wire           iRCLK,
  input  wire           iRRST,
  fifo_reader_if.slave  bus
);

  localparam logic [7:0] c_CNT_LAST = 8'(FRAMELEN - 1);

  logic                 r_startup;
  logic [1:0]           r_occ;
  logic [DATAWIDTH-1:0] r_slot0;
  logic [DATAWIDTH-1:0] r_slot1;
  logic [7:0]           r_cnt;

  logic                 w_push;
  logic                 w_xfer;
  logic [1:0]           w_occ_after_pop;
  logic [DATAWIDTH-1:0] w_slot0_nxt;
  logic [DATAWIDTH-1:0] w_slot1_nxt;
  logic [1:0]           w_occ_nxt;

  // Pop whenever enabled, data is there, the empty flag is trustworthy
  // (startup over) and a slot is free. Using occ<2 rather than looking at
  // iREADY keeps the pop strobe off the downstream combinational path.
  assign w_push = bus.iEN & ~bus.iEMPT & ~r_startup & (r_occ < 2'd2);
  assign w_xfer = (r_occ != 2'd0) & bus.iREADY;

  assign w_occ_after_pop = r_occ - {1'b0, w_xfer};

  // Next buffer contents: shift on transfer first, then drop the new word
  // into the lowest slot that is free after that shift.
  always_comb begin
    w_slot0_nxt = w_xfer ? r_slot1 : r_slot0;
    w_slot1_nxt = w_xfer ? '0      : r_slot1;
    if (w_push) begin
      if (w_occ_after_pop == 2'd0) begin
        w_slot0_nxt = bus.iRDAT;
      end else begin
        w_slot1_nxt = bus.iRDAT;
      end
    end
    w_occ_nxt = w_occ_after_pop + {1'b0, w_push};
  end

  // Startup mask: the FIFO empty flag is not valid on the first cycle out of reset
  always_ff @(posedge iRCLK or posedge iRRST) begin
    if (iRRST) begin
      r_startup <= 1'b1;
    end else begin
      r_startup <= 1'b0;
    end
  end

  // Two-entry buffer and its occupancy
  always_ff @(posedge iRCLK or posedge iRRST) begin
    if (iRRST) begin
      r_occ   <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
    end
  end

  // Position of the head word within the current frame
  always_ff @(posedge iRCLK or posedge iRRST) begin
    if (iRRST) begin
      r_cnt <= 8'd0;
    end else if (w_xfer) begin
      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.oRINC  = w_push;
  assign bus.oVALID = (r_occ != 2'd0);
  assign bus.oDATA  = r_slot0;
  assign bus.oCNT   = r_cnt;
  assign bus.oLAST  = (r_occ != 2'd0) & (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fifo_reader                                     |
// | Description : Directed self-checking bench for fifo_reader with  |
// |               a behavioural FIFO model on the read port.         |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_fifo_reader;

  localparam int c_DW = 8;
  localparam int c_FL = 4;

  logic clk;
  logic rst;

  fifo_reader_if #(.DATAWIDTH(c_DW)) bus ();

  fifo_reader #(
    .DATAWIDTH (c_DW),
    .FRAMELEN  (c_FL)
  ) u_dut (
    .iRCLK (clk),
    .iRRST (rst),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: writes from the stimulus process, reads on oRINC
  logic [c_DW-1:0] mem [0:255];
  logic [7:0]      wp;
  logic [7:0]      rp;

  initial rp = 8'd0;
  always @(posedge clk) begin
    if (bus.oRINC) rp <= rp + 8'd1;
  end

  assign bus.iEMPT = (wp == rp);
  assign bus.iRDAT = mem[rp];

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fifo_put(input logic [c_DW-1:0] d);
    mem[wp] = d;
    wp      = wp + 8'd1;
  endtask

  // Pulse reset across one edge, then let the startup edge pass
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  logic [7:0] rp_snap;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    wp         = 8'd0;
    rst        = 1'b1;
    bus.iEN    = 1'b1;
    bus.iREADY = 1'b1;

    // ---- Reset values, then an empty FIFO for 10 cycles ----
    @(negedge clk); #1;
    chk("rst_valid", 32'(bus.oVALID), 32'd0);
    chk("rst_rinc",  32'(bus.oRINC),  32'd0);
    chk("rst_cnt",   32'(bus.oCNT),   32'd0);
    chk("rst_last",  32'(bus.oLAST),  32'd0);
    chk("rst_data",  32'(bus.oDATA),  32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("idle_rinc",  32'(bus.oRINC),  32'd0);
      chk("idle_valid", 32'(bus.oVALID), 32'd0);
      chk("idle_cnt",   32'(bus.oCNT),   32'd0);
    end

    // ---- Preloaded 0x01..0x05 streams at one word per cycle ----
    do_reset();
    @(negedge clk);
    for (int i = 1; i <= 5; i++) fifo_put(8'(i));
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("str_rinc",  32'(bus.oRINC),  32'(k < 5));
      chk("str_valid", 32'(bus.oVALID), 32'(k >= 1 && k <= 5));
      if (k >= 1 && k <= 5) chk("str_data", 32'(bus.oDATA), 32'(k));
      @(negedge clk);
    end

    // ---- Backpressure: two pops, hold 0x01, then drain 1,2,3 ----
    do_reset();
    @(negedge clk);
    bus.iREADY = 1'b0;
    fifo_put(8'h01); fifo_put(8'h02); fifo_put(8'h03);
    #1;
    chk("bp_rinc0", 32'(bus.oRINC), 32'd1);
    @(negedge clk); #1;
    chk("bp_rinc1", 32'(bus.oRINC), 32'd1);
    chk("bp_data1", 32'(bus.oDATA), 32'h01);
    @(negedge clk); #1;
    chk("bp_rinc2", 32'(bus.oRINC), 32'd0);
    chk("bp_hold2", 32'(bus.oDATA), 32'h01);
    chk("bp_val2",  32'(bus.oVALID), 32'd1);
    @(negedge clk); #1;
    chk("bp_rinc3", 32'(bus.oRINC), 32'd0);
    chk("bp_hold3", 32'(bus.oDATA), 32'h01);
    bus.iREADY = 1'b1;
    #1;
    chk("bp_out1",  32'(bus.oDATA), 32'h01);
    chk("bp_rinc3r", 32'(bus.oRINC), 32'd0);
    @(negedge clk); #1;
    chk("bp_out2",  32'(bus.oDATA), 32'h02);
    chk("bp_rinc4", 32'(bus.oRINC), 32'd1);
    @(negedge clk); #1;
    chk("bp_out3",  32'(bus.oDATA), 32'h03);
    chk("bp_rinc5", 32'(bus.oRINC), 32'd0);
    @(negedge clk); #1;
    chk("bp_empty", 32'(bus.oVALID), 32'd0);

    // ---- Frames of 4: nine words, counter and last flag ----
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 9; i++) fifo_put(8'(8'h10 + i));
    for (int k = 0; k < 11; k++) begin
      #1;
      if (k >= 1 && k <= 9) begin
        chk("frm_data", 32'(bus.oDATA), 32'(8'h10 + k - 1));
        chk("frm_cnt",  32'(bus.oCNT),  32'((k - 1) % 4));
        chk("frm_last", 32'(bus.oLAST), 32'(((k - 1) % 4) == 3));
      end else begin
        chk("frm_idle_last", 32'(bus.oLAST), 32'd0);
      end
      @(negedge clk);
    end
    #1;
    chk("frm_cnt_end", 32'(bus.oCNT), 32'd1);

    // ---- Enable dropped with a full buffer ----
    do_reset();
    @(negedge clk);
    bus.iREADY = 1'b0;
    fifo_put(8'h21); fifo_put(8'h22); fifo_put(8'h23); fifo_put(8'h24);
    @(negedge clk);
    @(negedge clk);
    bus.iEN    = 1'b0;
    bus.iREADY = 1'b1;
    #1;
    chk("en_rinc_now", 32'(bus.oRINC), 32'd0);
    chk("en_out21",    32'(bus.oDATA), 32'h21);
    @(negedge clk); #1;
    chk("en_rinc_occ1", 32'(bus.oRINC), 32'd0);
    chk("en_out22",     32'(bus.oDATA), 32'h22);
    chk("en_val22",     32'(bus.oVALID), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("en_off_rinc",  32'(bus.oRINC),  32'd0);
      chk("en_off_valid", 32'(bus.oVALID), 32'd0);
    end
    bus.iEN = 1'b1;
    #1;
    chk("en_on_rinc", 32'(bus.oRINC), 32'd1);
    @(negedge clk); #1;
    chk("en_out23", 32'(bus.oDATA), 32'h23);
    bus.iEN = 1'b0;
    #1;
    chk("en_drop_same", 32'(bus.oRINC), 32'd0);
    bus.iEN = 1'b1;
    #1;
    @(negedge clk); #1;
    chk("en_out24", 32'(bus.oDATA), 32'h24);
    @(negedge clk); #1;
    chk("en_drained", 32'(bus.oVALID), 32'd0);

    // ---- Reset mid-operation with occ=2 and oCNT=2 ----
    do_reset();
    @(negedge clk);
    fifo_put(8'h31); fifo_put(8'h32);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.iREADY = 1'b0;
    fifo_put(8'h33); fifo_put(8'h34); fifo_put(8'h35);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mr_pre_cnt",  32'(bus.oCNT),  32'd2);
    chk("mr_pre_data", 32'(bus.oDATA), 32'h33);
    chk("mr_pre_rinc", 32'(bus.oRINC), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.oVALID), 32'd0);
    chk("mr_cnt",   32'(bus.oCNT),   32'd0);
    chk("mr_rinc",  32'(bus.oRINC),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    rp_snap = rp;
    chk("mr_rinc_rel", 32'(bus.oRINC), 32'd0);
    @(negedge clk); #1;
    chk("mr_no_pop_e1", 32'(rp),         32'(rp_snap));
    chk("mr_rinc_e2",   32'(bus.oRINC),  32'd1);
    chk("mr_valid_e2",  32'(bus.oVALID), 32'd0);
    @(negedge clk); #1;
    chk("mr_data", 32'(bus.oDATA), 32'h35);
    chk("mr_cnt0", 32'(bus.oCNT),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
